// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM encoding and default frame parameters.
package uart_tx_pkg;

    localparam int unsigned DEF_OVERSAMPLING  = 16;
    localparam int unsigned DEF_NUM_DATA_BITS = 8;
    localparam int unsigned NUM_PARITY_BIT    = 1;

    localparam int unsigned STATES_NUM = 5;
    localparam int unsigned STATE_W    = $clog2(STATES_NUM);

    // Receiver relies on IDLE..STOP_BIT keeping these values; START_BIT is appended.
    typedef enum logic [STATE_W-1:0] {
        StIdle      = STATE_W'(0),
        StDataBits  = STATE_W'(1),
        StParityBit = STATE_W'(2),
        StStopBit   = STATE_W'(3),
        StStartBit  = STATE_W'(4)
    } uart_state_e;

    // Parity bit from the XOR of all data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic xor_all, input logic odd);
        return xor_all ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and serial outputs of the UART transmitter.
interface uart_tx_if
    import uart_tx_pkg::*;
#(
    parameter int unsigned NUM_DATA_BITS = DEF_NUM_DATA_BITS
);
    logic                     enable;
    logic                     start;
    logic [NUM_DATA_BITS-1:0] data;
    logic                     ready;
    logic                     tx;
    logic                     busy;
    logic                     done;

    modport master (
        output enable, start, data,
        input  ready, tx, busy, done
    );

    modport slave (
        input  enable, start, data,
        output ready, tx, busy, done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Oversample counter: counts baud cycles within one bit, flags the last one.
module uart_bit_timer
    import uart_tx_pkg::*;
#(
    parameter int unsigned OVERSAMPLING = DEF_OVERSAMPLING
) (
    input  logic                            baud,
    input  logic                            reset,
    input  logic                            clear,
    output logic [$clog2(OVERSAMPLING)-1:0] os_idx,
    output logic                            bit_end
);
    localparam int unsigned OS_W = $clog2(OVERSAMPLING);

    logic [OS_W-1:0] os_idx_q;

    assign os_idx  = os_idx_q;
    assign bit_end = (os_idx_q == OS_W'(OVERSAMPLING - 1));

    // Free-running modulo-OVERSAMPLING count, restarted by clear.
    always_ff @(posedge baud or posedge reset) begin
        if (reset) begin
            os_idx_q <= '0;
        end else if (clear || bit_end) begin
            os_idx_q <= '0;
        end else begin
            os_idx_q <= os_idx_q + OS_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, data LSB first, parity, stop bit(s), with a
// one-word holding register for gap-free back-to-back frames.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned OVERSAMPLING  = DEF_OVERSAMPLING,
    parameter int unsigned NUM_DATA_BITS = DEF_NUM_DATA_BITS,
    parameter int unsigned PARITY_ODD    = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input logic      baud,
    input logic      reset,
    uart_tx_if.slave bus
);
    localparam int unsigned OS_W  = $clog2(OVERSAMPLING);
    localparam int unsigned BIT_W = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;

    uart_state_e              state_q;
    logic [NUM_DATA_BITS-1:0] hold_q;
    logic [NUM_DATA_BITS-1:0] shift_q;
    logic [NUM_DATA_BITS-1:0] shift_next;
    logic [BIT_W-1:0]         bit_idx_q;
    logic                     hold_valid_q;
    logic                     par_q;
    logic                     tx_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     ready_q;

    logic [OS_W-1:0] os_idx;
    logic            bit_end;
    logic            accept;
    logic            last_stop;
    logic            launch;
    logic            pre_done;
    logic            timer_clear;

    assign shift_next  = shift_q >> 1;
    assign accept      = bus.start && ready_q;
    assign last_stop   = (state_q == StStopBit) && bit_end &&
                         (bit_idx_q == BIT_W'(STOP_BITS - 1));
    assign launch      = bus.enable && hold_valid_q && ((state_q == StIdle) || last_stop);
    // done is registered, so arm it one cycle before the final stop cycle.
    assign pre_done    = (state_q == StStopBit) && (bit_idx_q == BIT_W'(STOP_BITS - 1)) &&
                         (os_idx == OS_W'(OVERSAMPLING - 2));
    assign timer_clear = !bus.enable || launch || (state_q == StIdle);

    uart_bit_timer #(
        .OVERSAMPLING(OVERSAMPLING)
    ) u_bit_timer (
        .baud   (baud),
        .reset  (reset),
        .clear  (timer_clear),
        .os_idx (os_idx),
        .bit_end(bit_end)
    );

    assign bus.ready = ready_q;
    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // Holding register, frame FSM and registered outputs.
    always_ff @(posedge baud or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            hold_valid_q <= 1'b0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else if (!bus.enable) begin
            state_q      <= StIdle;
            bit_idx_q    <= '0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            // ready can only be high while hold is empty, so accept never meets launch.
            ready_q <= !hold_valid_q && !accept;
            done_q  <= pre_done;

            if (accept) begin
                hold_q       <= bus.data;
                hold_valid_q <= 1'b1;
            end else if (launch) begin
                hold_valid_q <= 1'b0;
            end

            if (launch) begin
                shift_q   <= hold_q;
                par_q     <= parity_bit(^hold_q, PARITY_ODD != 0);
                bit_idx_q <= '0;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                state_q   <= StStartBit;
            end else begin
                case (state_q)
                    StIdle: begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                    StStartBit: begin
                        if (bit_end) begin
                            tx_q      <= shift_q[0];
                            bit_idx_q <= '0;
                            state_q   <= StDataBits;
                        end
                    end
                    StDataBits: begin
                        if (bit_end) begin
                            if (bit_idx_q == BIT_W'(NUM_DATA_BITS - 1)) begin
                                tx_q    <= par_q;
                                state_q <= StParityBit;
                            end else begin
                                shift_q   <= shift_next;
                                tx_q      <= shift_next[0];
                                bit_idx_q <= bit_idx_q + BIT_W'(1);
                            end
                        end
                    end
                    StParityBit: begin
                        if (bit_end) begin
                            tx_q      <= 1'b1;
                            bit_idx_q <= '0;
                            state_q   <= StStopBit;
                        end
                    end
                    StStopBit: begin
                        if (bit_end) begin
                            if (bit_idx_q == BIT_W'(STOP_BITS - 1)) begin
                                tx_q      <= 1'b1;
                                busy_q    <= 1'b0;
                                bit_idx_q <= '0;
                                state_q   <= StIdle;
                            end else begin
                                bit_idx_q <= bit_idx_q + BIT_W'(1);
                            end
                        end
                    end
                    default: begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one even-parity and one odd-parity instance share stimulus.
module tb_uart_tx;

    typedef struct packed {
        logic tx_e;
        logic tx_o;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
    } vec_t;

    logic       baud   = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] data   = 8'h00;

    int checks = 0;
    int errors = 0;

    exp_t       exp_q[$];
    int         inj_idx[$];
    logic [7:0] inj_dat[$];
    logic       inj_rdy[$];
    vec_t       vecs[10];

    uart_tx_if #(.NUM_DATA_BITS(8)) if_even ();
    uart_tx_if #(.NUM_DATA_BITS(8)) if_odd ();

    assign if_even.enable = enable;
    assign if_even.start  = start;
    assign if_even.data   = data;
    assign if_odd.enable  = enable;
    assign if_odd.start   = start;
    assign if_odd.data    = data;

    uart_tx #(
        .OVERSAMPLING (16),
        .NUM_DATA_BITS(8),
        .PARITY_ODD   (0),
        .STOP_BITS    (1)
    ) u_even (
        .baud (baud),
        .reset(reset),
        .bus  (if_even.slave)
    );

    uart_tx #(
        .OVERSAMPLING (16),
        .NUM_DATA_BITS(8),
        .PARITY_ODD   (1),
        .STOP_BITS    (1)
    ) u_odd (
        .baud (baud),
        .reset(reset),
        .bus  (if_odd.slave)
    );

    always #5 baud = ~baud;

    task automatic check(input string name, input int idx, input string what,
                         input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] %s: got %b expected %b", name, idx, what, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud);
        #1;
    endtask

    task automatic clear_plan();
        exp_q.delete();
        inj_idx.delete();
        inj_dat.delete();
        inj_rdy.delete();
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{tx_e: 1'b1, tx_o: 1'b1, busy: 1'b0,
                                                     done: 1'b0});
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic po);
        logic be, bo;
        for (int b = 0; b < 11; b++) begin
            if (b == 0) begin
                be = 1'b0; bo = 1'b0;
            end else if (b <= 8) begin
                be = d[b-1]; bo = d[b-1];
            end else if (b == 9) begin
                be = pe; bo = po;
            end else begin
                be = 1'b1; bo = 1'b1;
            end
            for (int c = 0; c < 16; c++)
                exp_q.push_back('{tx_e: be, tx_o: bo, busy: 1'b1,
                                  done: (b == 10 && c == 15)});
        end
    endtask

    task automatic add_inj(input int idx, input logic [7:0] d, input logic rdy);
        inj_idx.push_back(idx);
        inj_dat.push_back(d);
        inj_rdy.push_back(rdy);
    endtask

    // Walk the expected waveform cycle by cycle, pulsing start where planned.
    task automatic run_expect(input string name);
        int   k = 0;
        logic was_acc = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check(name, i, "tx_even", if_even.tx, exp_q[i].tx_e);
            check(name, i, "tx_odd", if_odd.tx, exp_q[i].tx_o);
            check(name, i, "busy_even", if_even.busy, exp_q[i].busy);
            check(name, i, "busy_odd", if_odd.busy, exp_q[i].busy);
            check(name, i, "done_even", if_even.done, exp_q[i].done);
            check(name, i, "done_odd", if_odd.done, exp_q[i].done);
            if (was_acc) check(name, i, "ready_after_accept", if_even.ready, 1'b0);
            was_acc = 1'b0;
            start   = 1'b0;
            if (k < inj_idx.size() && inj_idx[k] == i) begin
                check(name, i, "ready_at_start", if_even.ready, inj_rdy[k]);
                start   = 1'b1;
                data    = inj_dat[k];
                was_acc = inj_rdy[k];
                k++;
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, par_even: 1'b0, par_odd: 1'b1};
        vecs[1] = '{data: 8'h07, par_even: 1'b1, par_odd: 1'b0};
        vecs[2] = '{data: 8'h00, par_even: 1'b0, par_odd: 1'b1};
        vecs[3] = '{data: 8'hFF, par_even: 1'b0, par_odd: 1'b1};
        vecs[4] = '{data: 8'h01, par_even: 1'b1, par_odd: 1'b0};
        vecs[5] = '{data: 8'h80, par_even: 1'b1, par_odd: 1'b0};
        vecs[6] = '{data: 8'h7F, par_even: 1'b1, par_odd: 1'b0};
        vecs[7] = '{data: 8'h96, par_even: 1'b0, par_odd: 1'b1};
        vecs[8] = '{data: 8'h0E, par_even: 1'b1, par_odd: 1'b0};
        vecs[9] = '{data: 8'hE0, par_even: 1'b1, par_odd: 1'b0};

        // Reset held for 3 cycles with enable high.
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset", i, "tx", if_even.tx, 1'b1);
            check("reset", i, "busy", if_even.busy, 1'b0);
            check("reset", i, "done", if_even.done, 1'b0);
            check("reset", i, "ready", if_even.ready, 1'b0);
        end
        reset = 1'b0;
        #1;
        check("reset_release", 0, "ready", if_even.ready, 1'b0);
        tick();
        check("reset_release", 1, "ready_even", if_even.ready, 1'b1);
        check("reset_release", 1, "ready_odd", if_odd.ready, 1'b1);
        check("reset_release", 1, "tx", if_even.tx, 1'b1);

        // Single frames from the table; first one also tries an ignored start.
        for (int v = 0; v < 10; v++) begin
            clear_plan();
            push_idle(2);
            push_frame(vecs[v].data, vecs[v].par_even, vecs[v].par_odd);
            push_idle(1);
            add_inj(0, vecs[v].data, 1'b1);
            if (v == 0) add_inj(1, 8'hFF, 1'b0);
            run_expect($sformatf("frame_%02h", vecs[v].data));
        end

        // Back-to-back: second word queued during data bits, third start ignored.
        clear_plan();
        push_idle(2);
        push_frame(8'h3C, 1'b0, 1'b1);
        push_frame(8'hC3, 1'b0, 1'b1);
        push_idle(1);
        add_inj(0, 8'h3C, 1'b1);
        add_inj(42, 8'hC3, 1'b1);
        add_inj(43, 8'hFF, 1'b0);
        run_expect("b2b");

        // Start on the final stop cycle: exactly one idle cycle before next frame.
        clear_plan();
        push_idle(2);
        push_frame(8'hA5, 1'b0, 1'b1);
        push_idle(1);
        push_frame(8'h55, 1'b0, 1'b1);
        push_idle(1);
        add_inj(0, 8'hA5, 1'b1);
        add_inj(177, 8'h55, 1'b1);
        run_expect("last_stop_start");

        // Abort by dropping enable on data bit 4 with a word queued.
        start = 1'b1; data = 8'hA5;
        tick();
        start = 1'b0;
        tick();
        repeat (9) tick();
        check("abort", 0, "ready_before_queue", if_even.ready, 1'b1);
        start = 1'b1; data = 8'h3C;
        tick();
        start = 1'b0;
        check("abort", 1, "ready_queued", if_even.ready, 1'b0);
        repeat (74) tick();
        check("abort", 2, "tx_data_bit4", if_even.tx, 1'b0);
        check("abort", 2, "busy_before", if_even.busy, 1'b1);
        enable = 1'b0;
        tick();
        check("abort", 3, "tx", if_even.tx, 1'b1);
        check("abort", 3, "busy", if_even.busy, 1'b0);
        check("abort", 3, "done", if_even.done, 1'b0);
        check("abort", 3, "ready", if_even.ready, 1'b0);
        repeat (3) tick();
        check("abort", 4, "ready_disabled", if_even.ready, 1'b0);
        check("abort", 4, "tx_disabled", if_odd.tx, 1'b1);
        enable = 1'b1;
        tick();
        check("abort", 5, "ready_recover", if_even.ready, 1'b1);
        for (int i = 0; i < 200; i++) begin
            check("abort_discard", i, "tx", if_even.tx, 1'b1);
            check("abort_discard", i, "busy", if_even.busy, 1'b0);
            check("abort_discard", i, "done", if_even.done, 1'b0);
            tick();
        end

        // Asynchronous reset during the parity bit of 0x07.
        start = 1'b1; data = 8'h07;
        tick();
        start = 1'b0;
        tick();
        repeat (150) tick();
        check("rst_mid", 0, "parity_even", if_even.tx, 1'b1);
        check("rst_mid", 0, "parity_odd", if_odd.tx, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("rst_mid", 1, "tx_even", if_even.tx, 1'b1);
        check("rst_mid", 1, "tx_odd", if_odd.tx, 1'b1);
        check("rst_mid", 1, "busy", if_even.busy, 1'b0);
        check("rst_mid", 1, "done", if_even.done, 1'b0);
        check("rst_mid", 1, "ready", if_even.ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_hold", i, "done", if_even.done, 1'b0);
            check("rst_mid_hold", i, "tx", if_even.tx, 1'b1);
        end
        reset = 1'b0;
        tick();
        check("rst_mid", 2, "ready", if_even.ready, 1'b1);
        check("rst_mid", 2, "busy", if_even.busy, 1'b0);

        // Loopback-style run: 256 words 0x00..0xFF gap-free, decoded from the line.
        clear_plan();
        push_idle(2);
        for (int w = 0; w < 256; w++) begin
            logic [7:0] d;
            d = 8'(w);
            push_frame(d, ^d, ~(^d));
            if (w == 0) add_inj(0, d, 1'b1);
            else add_inj(2 + (w - 1) * 176 + 40, d, 1'b1);
        end
        push_idle(1);
        run_expect("stream");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one data word per frame onto the `tx` line as start bit, data bits LSB first, one parity bit and stop bit(s). It runs on the same oversampled `baud` clock as the UART receiver, so the two blocks form a matched pair and can be looped back. A one-entry holding register lets the host queue the next word while the current frame is still shifting, giving gap-free back-to-back frames.

## Interface
- `OVERSAMPLING`, 16: `baud` cycles per bit; must be ≥ 2.
- `NUM_DATA_BITS`, 8: data bits per frame.
- `PARITY_ODD`, 0: 0 selects even parity (parity bit = XOR of data), 1 selects odd parity (parity bit = XNOR of data).
- `STOP_BITS`, 1: stop bits per frame; legal values are 1 and 2.

- `baud` input 1: the oversampled clock, the only clock in the block.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: the transmitter operates only while this is high.
- `start` input 1: request to send `data`; accepted on an edge where `start && ready`.
- `data` input NUM_DATA_BITS: word to send; sampled only on the acceptance edge.
- `ready` output 1: registered; high when the holding register is empty and `enable` is high.
- `tx` output 1: registered serial line, idle level 1.
- `busy` output 1: registered; high from the first start-bit cycle to the last stop-bit cycle.
- `done` output 1: registered one-cycle pulse on the last cycle of the final stop bit.

## Operation
- **States:** IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT. The state register width is taken from the shared state count.
- **Counters:**
  - `os_idx`: 0..OVERSAMPLING-1, counts cycles within the current bit.
  - `bit_idx`: 0..NUM_DATA_BITS-1 in DATA_BITS; 0..STOP_BITS-1 in STOP_BIT.
- **Accept:** when `start && ready` at an edge, the block loads `hold <= data`, sets `hold_valid <= 1` and drives `ready <= 0`.
- **Frame launch:** when the FSM is in IDLE with `hold_valid`, or at the end of the final stop bit with `hold_valid`:
  - load `shift <= hold` and compute `par` from `hold`;
  - clear `hold_valid`, so `ready` rises at the next edge;
  - set `tx <= 0`, `busy <= 1`, `os_idx <= 0`, state START_BIT.
- **Bit advance:** when `os_idx == OVERSAMPLING-1`, set `os_idx <= 0` and move to the next bit. Otherwise increment `os_idx`.
  - START_BIT → DATA_BITS, with `tx <= shift[0]`.
  - Each data bit: shift right and drive the new `shift[0]`. After bit NUM_DATA_BITS-1, go to PARITY_BIT with `tx <= par`.
  - PARITY_BIT → STOP_BIT, with `tx <= 1`.
  - STOP_BIT: at the end of bit STOP_BITS-1, pulse `done`. Then launch the next frame if `hold_valid`, else go to IDLE with `busy <= 0`.
- **Parity:** computed from the word as loaded, never from the partially shifted register.
- **`enable` low:** at the next edge the block aborts any frame and clears the holding register.
  - Outputs: `tx <= 1`, `busy <= 0`, `done <= 0`, `ready <= 0`, state IDLE.
  - Recovery: `ready` returns to 1 one edge after `enable` rises.
- **Illegal state encoding:** go to IDLE with `tx <= 1`.

## Timing
- **Reset values:**
  - Outputs: `tx`=1, `busy`=0, `done`=0, `ready`=0.
  - Internal: state IDLE, `hold_valid`=0, counters 0.
  - `ready` rises on the first edge after reset is released while `enable` is high.
- **Launch latency:** if accepted in IDLE at edge k, `tx` falls at edge k+1.
- **Bit length:** every bit lasts exactly OVERSAMPLING cycles.
- **Frame length:** (1 + NUM_DATA_BITS + 1 + STOP_BITS) × OVERSAMPLING cycles.
  - With the defaults this is 11 × 16 = 176 cycles.
- **Back-to-back frames:**
  - If `hold_valid` was set before the final stop cycle, the next start bit follows immediately with zero idle cycles.
  - If `start` is accepted on the final stop cycle itself, the FSM goes to IDLE, `tx` stays high for exactly 1 cycle, and the frame then launches.
- **`done` and `busy`:**
  - `done` is high on the final stop cycle only.
  - `busy` deasserts on the edge after the final stop cycle unless a new frame launches.
- **`start` while `ready` is low:** ignored. `hold` is not overwritten.
- **Reset asserted mid-frame:** all registers take their reset values immediately; no `done` pulse is produced.

## Structure
- Add to `uart_globals.svh`:
  - `STATE_START_BIT`, plus an updated `STATES_NUM`;
  - shared defaults for `OVERSAMPLING`, `NUM_DATA_BITS` and `NUM_PARITY_BIT`;
  - keep the existing IDLE, DATA_BITS, PARITY_BIT and STOP_BIT encodings unchanged.
- Sub-module `uart_bit_timer`:
  - holds `os_idx` and asserts `bit_end` when `os_idx == OVERSAMPLING-1`;
  - takes a `clear` input;
  - is reusable by the receiver.

## Test plan
- **Reset and idle:** hold `reset` for 3 cycles, then `enable`=1 → `tx`=1, `busy`=0, `done`=0 throughout; `ready`=1 one edge after reset release.
- **Even-parity frame:** send `data`=0xA5 with PARITY_ODD=0 → `tx` bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 16 cycles; `done` on cycle 176; `busy` high for cycles 1..176.
- **Odd-parity frame:** send 0x07 with PARITY_ODD=1 → parity bit 0; send 0x00 → parity bit 1.
- **Back-to-back frames:**
  - 0x3C, then 0xC3 issued while the first frame is still in its data bits → second start bit immediately after the first stop bit, zero gap, two `done` pulses 176 cycles apart.
  - `start` with 0x55 on the final stop cycle → exactly 1 idle cycle before the next frame.
- **Abort:** drop `enable` on data bit 4 → `tx`=1 and `busy`=0 at the next edge, no `done`, queued word discarded. Reset mid-parity-bit → same outputs asynchronously.
- **Loopback:** connect `tx` to `uart_rx` `rx` and send 256 words 0x00..0xFF back-to-back → receiver `data` matches each word, `error` never asserted.
